// File: rtl/timer_sched_pkg.sv
// Shared types and default sizing for the timer scheduler.
package timer_sched_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PRESCALE = 10;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/timer_scheduler_if.sv
// Configuration, control strobes and expiry event handshake of the timer scheduler.
interface timer_scheduler_if
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int ID_W = $clog2(NUM_CH);

  logic              cfg_we;
  logic [ID_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_reload;
  logic              cfg_periodic;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic              evt_valid;
  logic              evt_ready;
  logic [ID_W-1:0]   evt_id;
  logic              evt_overrun;

  // Host side: configures channels and consumes events.
  modport master (
    output cfg_we, cfg_ch, cfg_reload, cfg_periodic, start, stop, evt_ready,
    input  evt_valid, evt_id, evt_overrun
  );

  // Scheduler side.
  modport slave (
    input  cfg_we, cfg_ch, cfg_reload, cfg_periodic, start, stop, evt_ready,
    output evt_valid, evt_id, evt_overrun
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle timebase tick every PRESCALE clocks.
module tick_prescaler
  import timer_sched_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count wraps to zero after the last phase.
  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  // Counter and registered tick, aligned so tick is high while cnt_q == LAST.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel down-counting timers with a round-robin expiry event queue.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  timer_scheduler_if.slave   bus,
  output logic [NUM_CH-1:0]  active,
  output logic               tick
);
  localparam int ID_W = $clog2(NUM_CH);

  ch_state_e         state_q  [NUM_CH];
  ch_state_e         state_d  [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  reload_q [NUM_CH];
  logic [NUM_CH-1:0] periodic_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] hs_clr;
  logic [NUM_CH-1:0] avail;
  logic              hs;
  logic [ID_W-1:0]   ptr_q, ptr_sel, next_ptr, sel_id, rr_idx;
  logic              sel_found;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign hs       = bus.evt_valid & bus.evt_ready;
  assign next_ptr = (bus.evt_id == ID_W'(NUM_CH - 1)) ? '0 : bus.evt_id + 1'b1;

  // Reload/mode registers written by the configuration port.
  // NOTE: the reload array is reset like ordinary flops so a start before any configuration loads a known 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) reload_q[i] <= '0;
      periodic_q <= '0;
    end else if (bus.cfg_we) begin
      reload_q[bus.cfg_ch]   <= bus.cfg_reload;
      periodic_q[bus.cfg_ch] <= bus.cfg_periodic;
    end
  end

  // Channel next state: stop beats start, start beats a coinciding expiry.
  // NOTE: every output of this block is defaulted first so no path leaves a latch.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      expire[i]  = 1'b0;
      if (bus.stop[i]) begin
        state_d[i] = CH_IDLE;
      end else if (bus.start[i]) begin
        state_d[i] = CH_RUN;
        count_d[i] = reload_q[i];
      end else if (state_q[i] == CH_RUN && tick) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - 1'b1;
        end else begin
          expire[i] = 1'b1;
          if (periodic_q[i]) count_d[i] = reload_q[i];
          else               state_d[i] = CH_IDLE;
        end
      end
    end
  end

  // Channel state and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_IDLE;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // Channel outputs.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) active[i] = (state_q[i] == CH_RUN);
  end

  // Pending/overrun update: a new expiry wins over the handshake clear of the same channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hs_clr[i]    = hs && (bus.evt_id == ID_W'(i));
      pending_d[i] = expire[i] | (pending_q[i] & ~hs_clr[i]);
      overrun_d[i] = ~hs_clr[i] & (overrun_q[i] | (expire[i] & pending_q[i]));
    end
  end

  // Round-robin pick of the first pending channel at or after the pointer.
  always_comb begin
    ptr_sel   = hs ? next_ptr : ptr_q;
    avail     = pending_q & ~hs_clr;
    sel_found = 1'b0;
    sel_id    = '0;
    rr_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_idx = ID_W'((int'(ptr_sel) + k) % NUM_CH);
      if (!sel_found && avail[rr_idx]) begin
        sel_found = 1'b1;
        sel_id    = rr_idx;
      end
    end
  end

  // Pending flags, pointer and the registered event presentation stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q       <= '0;
      overrun_q       <= '0;
      ptr_q           <= '0;
      bus.evt_valid   <= 1'b0;
      bus.evt_id      <= '0;
      bus.evt_overrun <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (hs) ptr_q <= next_ptr;
      if (!bus.evt_valid || hs) begin
        bus.evt_valid   <= sel_found;
        bus.evt_id      <= sel_id;
        bus.evt_overrun <= sel_found & overrun_q[sel_id];
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with PRESCALE=4, NUM_CH=4.
module tb_timer_scheduler;
  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 4;
  localparam int CNT_W    = 16;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] active;
  logic              tick;
  int                checks = 0;
  int                errors = 0;

  timer_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  timer_scheduler #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .active (active),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, n);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.evt_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: evt_valid=%b after %0d cycles, required 1", name, bus.evt_valid, n);
    end
  endtask

  task automatic write_cfg(input int ch, input logic [CNT_W-1:0] r, input logic per);
    bus.cfg_we       = 1'b1;
    bus.cfg_ch       = 2'(ch);
    bus.cfg_reload   = r;
    bus.cfg_periodic = per;
    cyc();
    bus.cfg_we       = 1'b0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    bus.start = m;
    cyc();
    bus.start = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({bus.evt_valid, bus.evt_id, bus.evt_overrun, tick, active} !== 9'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b id=%0d ov=%b tick=%b active=%b, required all 0",
               bus.evt_valid, bus.evt_id, bus.evt_overrun, tick, active);
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (tick !== ((k % 4) == 3) || bus.evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL tick_phase[%0d]: tick=%b valid=%b, required tick=%b valid=0",
                 k, tick, bus.evt_valid, (k % 4) == 3);
      end
      cyc();
    end
  endtask

  task automatic test_one_shot();
    int seen = 0;
    bus.evt_ready = 1'b1;
    write_cfg(0, 16'd2, 1'b0);
    pulse_start(4'b0001);
    checks++;
    if (active !== 4'b0001) begin
      errors++;
      $display("FAIL one_shot_active: active=%b, required 0001", active);
    end
    wait_tick(); cyc();
    wait_tick(); cyc();
    wait_tick();
    checks++;
    if (active[0] !== 1'b1 || bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_pre: active0=%b valid=%b, required 1/0", active[0], bus.evt_valid);
    end
    cyc();
    checks++;
    if (active[0] !== 1'b0 || bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_fall: active0=%b valid=%b, required 0/0", active[0], bus.evt_valid);
    end
    cyc();
    checks++;
    if ({bus.evt_valid, bus.evt_id, bus.evt_overrun} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL one_shot_event: valid=%b id=%0d ov=%b, required 1/0/0",
               bus.evt_valid, bus.evt_id, bus.evt_overrun);
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.evt_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL one_shot_single: %0d extra event cycles, required 0", seen);
    end
  endtask

  task automatic test_stop_start();
    int seen = 0;
    bus.evt_ready = 1'b1;
    write_cfg(2, 16'd1, 1'b1);
    pulse_start(4'b0100);
    wait_valid("stop_start_first");
    checks++;
    if (bus.evt_id !== 2'd2) begin
      errors++;
      $display("FAIL stop_start_id: id=%0d, required 2", bus.evt_id);
    end
    bus.start = 4'b0100;
    bus.stop  = 4'b0100;
    cyc();
    bus.start = '0;
    bus.stop  = '0;
    checks++;
    if (active !== 4'b0000 || bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_wins: active=%b valid=%b, required 0000/0", active, bus.evt_valid);
    end
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.evt_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stop_quiet: %0d event cycles after stop, required 0", seen);
    end
  endtask

  task automatic test_overrun_order();
    logic [3:0] exp_ev [3];
    exp_ev[0] = {1'b1, 2'd1, 1'b1};
    exp_ev[1] = {1'b1, 2'd2, 1'b1};
    exp_ev[2] = {1'b1, 2'd3, 1'b1};
    bus.evt_ready = 1'b0;
    write_cfg(0, 16'd0, 1'b0);
    pulse_start(4'b0001);
    wait_valid("hold_first");
    write_cfg(1, 16'd0, 1'b1);
    write_cfg(2, 16'd0, 1'b1);
    write_cfg(3, 16'd0, 1'b1);
    pulse_start(4'b1110);
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if ({bus.evt_valid, bus.evt_id, bus.evt_overrun} !== {1'b1, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b id=%0d ov=%b, required 1/0/0",
                 k, bus.evt_valid, bus.evt_id, bus.evt_overrun);
      end
    end
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if ({bus.evt_valid, bus.evt_id, bus.evt_overrun} !== exp_ev[k]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: valid=%b id=%0d ov=%b, required 1/%0d/1",
                 k, bus.evt_valid, bus.evt_id, bus.evt_overrun, k + 1);
      end
    end
    bus.stop = 4'hF;
    cyc();
    bus.stop = '0;
    repeat (10) cyc();
    checks++;
    if (bus.evt_valid !== 1'b0 || active !== 4'b0000) begin
      errors++;
      $display("FAIL drain: valid=%b active=%b, required 0/0000", bus.evt_valid, active);
    end
  endtask

  task automatic test_reset_pending();
    int seen = 0;
    bus.evt_ready = 1'b0;
    write_cfg(1, 16'd0, 1'b0);
    write_cfg(2, 16'd0, 1'b0);
    write_cfg(3, 16'd0, 1'b0);
    pulse_start(4'b1110);
    wait_valid("pending_before_reset");
    cyc();
    cyc();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.evt_valid, bus.evt_id, bus.evt_overrun, tick, active} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b id=%0d ov=%b tick=%b active=%b, required all 0",
               bus.evt_valid, bus.evt_id, bus.evt_overrun, tick, active);
    end
    repeat (2) cyc();
    reset = 1'b1;
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.evt_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_discard: %0d event cycles after release, required 0", seen);
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_ch       = '0;
    bus.cfg_reload   = '0;
    bus.cfg_periodic = 1'b0;
    bus.start        = '0;
    bus.stop         = '0;
    bus.evt_ready    = 1'b0;
    test_reset();
    test_one_shot();
    test_stop_start();
    test_overrun_order();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
